// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path.
//   SPI_WORD_WIDTH : default number of bits in one SPI word
//   spi_word_t     : one received SPI word
package spi_pkg;

    localparam int SPI_WORD_WIDTH = 8;

    typedef logic [SPI_WORD_WIDTH-1:0] spi_word_t;

endpackage : spi_pkg

// File: rtl/spi_buffer.sv
// SPI slave receive buffer. Shifts DI in MSB first while CS is low and the
// system reports IsInitialized. Each complete word is latched into Buffer,
// and Changed pulses for one clock.
//
// Ports:
//   CLK           : SPI serial clock; every register updates on its rising edge
//   reset         : synchronous, active-high reset
//   DI            : serial data in (MOSI)
//   CS            : chip select, active low
//   IsInitialized : receive enable; 0 holds the receiver idle
//   Buffer        : last completely received word
//   Changed       : one-cycle strobe marking a new word in Buffer
module spi_buffer
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             DI,
    input  logic             CS,
    input  logic             IsInitialized,
    output logic [WIDTH-1:0] Buffer,
    output logic             Changed
);

    localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] srNext;
    logic [CntW-1:0]  cnt;
    logic             idle;

    // The word completes from the bit sampled on this edge, so Buffer is
    // loaded from the shifted value rather than from sr itself.
    assign srNext = {sr[WIDTH-2:0], DI};
    assign idle   = CS || !IsInitialized;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sr      <= '0;
            cnt     <= '0;
            Buffer  <= '0;
            Changed <= 1'b0;
        end else if (idle) begin
            // Any partial word is dropped; the next select starts at bit 0.
            sr      <= '0;
            cnt     <= '0;
            Changed <= 1'b0;
        end else begin
            sr <= srNext;
            if (cnt == LastCnt) begin
                Buffer  <= srNext;
                Changed <= 1'b1;
                cnt     <= '0;
            end else begin
                cnt     <= cnt + 1'b1;
                Changed <= 1'b0;
            end
        end
    end

endmodule : spi_buffer

// File: tb/tb_spi_buffer.sv
// Self-checking bench for spi_buffer: directed sequences followed by
// randomized traffic, all compared against a bit-queue reference model.
module tb_spi_buffer;
    import spi_pkg::*;

    localparam int W = SPI_WORD_WIDTH;

    logic      CLK = 1'b0;
    logic      reset = 1'b0;
    logic      DI = 1'b0;
    logic      CS = 1'b1;
    logic      IsInitialized = 1'b1;
    spi_word_t Buffer;
    logic      Changed;

    int nChecks = 0;
    int nFail = 0;

    // Reference model: bits of the word in progress, plus expected outputs.
    int        bitQ[$];
    spi_word_t expBuf = '0;
    logic      expChg = 1'b0;
    int        pulseCount = 0;

    spi_buffer #(.WIDTH(W)) dut (
        .CLK(CLK),
        .reset(reset),
        .DI(DI),
        .CS(CS),
        .IsInitialized(IsInitialized),
        .Buffer(Buffer),
        .Changed(Changed)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one clock's worth of inputs, advance the model, compare outputs.
    task automatic step(input logic rstIn, input logic csIn, input logic initIn, input logic diIn);
        int w;
        @(negedge CLK);
        reset = rstIn;
        CS = csIn;
        IsInitialized = initIn;
        DI = diIn;
        @(posedge CLK);
        #1;
        if (rstIn) begin
            bitQ.delete();
            expBuf = '0;
            expChg = 1'b0;
        end else if (csIn || !initIn) begin
            bitQ.delete();
            expChg = 1'b0;
        end else begin
            bitQ.push_back(int'(diIn));
            if (bitQ.size() == W) begin
                w = 0;
                foreach (bitQ[i]) w = w * 2 + bitQ[i];
                expBuf = spi_word_t'(w);
                expChg = 1'b1;
                bitQ.delete();
            end else begin
                expChg = 1'b0;
            end
        end
        if (Changed === 1'b1) pulseCount++;
        checkVal("Buffer", 32'(Buffer), 32'(expBuf));
        checkVal("Changed", 32'(Changed), 32'(expChg));
    endtask

    task automatic sendWord(input spi_word_t b);
        for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, b[i]);
    endtask

    int pulsesBefore;
    spi_word_t tmpWord;

    initial begin
        // 1. reset
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        checkVal("resetBuffer", 32'(Buffer), 32'h00);
        checkVal("resetChanged", 32'(Changed), 32'h0);

        // 2. idle then 0x7A
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        sendWord(8'h7A);
        checkVal("word7A", 32'(Buffer), 32'h7A);
        checkVal("pulse7A", 32'(Changed), 32'h1);

        // 3. back-to-back 0x80, no pulse in between
        pulsesBefore = pulseCount;
        sendWord(8'h80);
        checkVal("word80", 32'(Buffer), 32'h80);
        checkVal("pulses80", 32'(pulseCount - pulsesBefore), 32'd1);

        // 4. idle, then 0x0C and 0x40, then one extra edge
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        sendWord(8'h0C);
        checkVal("word0C", 32'(Buffer), 32'h0C);
        sendWord(8'h40);
        checkVal("word40", 32'(Buffer), 32'h40);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        checkVal("extraEdgeChanged", 32'(Changed), 32'h0);
        checkVal("extraEdgeBuffer", 32'(Buffer), 32'h40);

        // 5. partial word aborted by CS, then 0xA5
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        sendWord(8'hA5);
        checkVal("wordA5", 32'(Buffer), 32'hA5);

        // 6. not initialized for 16 edges, then 0x3C
        pulsesBefore = pulseCount;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'(i % 3));
        checkVal("uninitPulses", 32'(pulseCount - pulsesBefore), 32'd0);
        checkVal("uninitBuffer", 32'(Buffer), 32'hA5);
        sendWord(8'h3C);
        checkVal("word3C", 32'(Buffer), 32'h3C);

        // IsInitialized dropping mid-word discards the partial word
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        sendWord(8'h5A);
        checkVal("word5A", 32'(Buffer), 32'h5A);

        // reset on the last-bit edge wins
        tmpWord = 8'hFF;
        for (int i = W - 1; i >= 1; i--) step(1'b0, 1'b0, 1'b1, tmpWord[i]);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        checkVal("resetLastBitBuffer", 32'(Buffer), 32'h00);
        checkVal("resetLastBitChanged", 32'(Changed), 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 39) != 0,
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_spi_buffer
